mux_41_rr_arbiter: RTL and testbench

MUX_41_RR_ARBITER -- requirements
Module: mux_41_rr_arbiter

---
 rtl/mux_41_rr_arbiter_if.sv | 26 ++
 rtl/mux_41_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_mux_41_rr_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_41_rr_arbiter_if.sv
// Bus bundle for the 4:1 round-robin arbitrated mux.
// master: the side that raises requests and supplies source data.
// slave : the arbiter/mux itself.
interface mux_41_rr_arbiter_if #(
   parameter int DATA_W = 8
);
   logic [3:0]        req;
   logic [DATA_W-1:0] i0;
   logic [DATA_W-1:0] i1;
   logic [DATA_W-1:0] i2;
   logic [DATA_W-1:0] i3;
   logic [3:0]        grant;
   logic [1:0]        sel;
   logic [DATA_W-1:0] out;
   logic              out_valid;

   modport master (
      output req, i0, i1, i2, i3,
      input  grant, sel, out, out_valid
   );

   modport slave (
      input  req, i0, i1, i2, i3,
      output grant, sel, out, out_valid
   );
endinterface

// File: rtl/mux_41_rr_arbiter.sv
// 4:1 data mux whose select is owned by a round-robin arbiter.
// One source owns the mux until it drops its request; ownership then passes
// through a single dead cycle (SWITCH) to the next requester in rotation.
// Optional: define MUX_41_ARB_TIMEOUT_EN to cap a tenure at HOLD_MAX cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no owner, waiting for any request
// GRANT  | owner holds the mux, out follows i[owner] every cycle
// SWITCH | one dead cycle after a tenure, grant = 0, out held
module mux_41_rr_arbiter #(
   parameter int DATA_W   = 8,
   parameter int HOLD_MAX = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mux_41_rr_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      SWITCH = 2'd2
   } state_t;

   localparam logic [3:0] TENURE_LAST = 4'(HOLD_MAX - 1);

   state_t            state;
   logic [3:0]        grant_q;
   logic [1:0]        sel_q;
   logic [DATA_W-1:0] out_q;
   logic              valid_q;
   logic [1:0]        last_owner;

   logic [1:0]        rr_winner;
   logic              rr_found;
   logic [1:0]        rr_idx;
   logic [DATA_W-1:0] owner_data;
   logic              tenure_hit;

   // Round-robin search starting one past the last owner, wrapping 3 -> 0.
   always_comb begin
      rr_found  = 1'b0;
      rr_winner = 2'd0;
      rr_idx    = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         rr_idx = last_owner + 2'(k);
         if (!rr_found && bus.req[rr_idx]) begin
            rr_found  = 1'b1;
            rr_winner = rr_idx;
         end
      end
   end

   // Data mux driven by the registered owner (sel_q doubles as owner).
   always_comb begin
      owner_data = bus.i0;
      case (sel_q)
         2'd0:    owner_data = bus.i0;
         2'd1:    owner_data = bus.i1;
         2'd2:    owner_data = bus.i2;
         default: owner_data = bus.i3;
      endcase
   end

`ifdef MUX_41_ARB_TIMEOUT_EN
   logic [3:0] tenure;

   // Tenure counter: held at zero outside GRANT so every tenure starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tenure <= 4'd0;
      end else if (state != GRANT) begin
         tenure <= 4'd0;
      end else begin
         tenure <= tenure + 4'd1;
      end
   end

   assign tenure_hit = (state == GRANT) && (tenure == TENURE_LAST);
`else
   logic unused_hold;

   assign unused_hold = ^TENURE_LAST;
   assign tenure_hit  = 1'b0;
`endif

   // Arbitration FSM with all bus outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant_q    <= 4'b0000;
         sel_q      <= 2'd0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         last_owner <= 2'd3;
      end else begin
         case (state)
            IDLE, SWITCH: begin
               valid_q <= 1'b0;
               if (rr_found) begin
                  state   <= GRANT;
                  grant_q <= 4'b0001 << rr_winner;
                  sel_q   <= rr_winner;
               end else begin
                  state   <= IDLE;
                  grant_q <= 4'b0000;
               end
            end
            GRANT: begin
               if (!bus.req[sel_q] || tenure_hit) begin
                  state      <= SWITCH;
                  grant_q    <= 4'b0000;
                  valid_q    <= 1'b0;
                  last_owner <= sel_q;
               end else begin
                  out_q   <= owner_data;
                  valid_q <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= 4'b0000;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.sel       = sel_q;
   assign bus.out       = out_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_41_rr_arbiter.sv
// Directed bench for mux_41_rr_arbiter: a cycle table plus hand-written
// rotation, reset-abort and tenure sequences, with an always-on grant monitor.
module tb_mux_41_rr_arbiter;
   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_41_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

   mux_41_rr_arbiter #(.DATA_W(DATA_W), .HOLD_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] req;
      logic [7:0] i0;
      logic [3:0] grant;
      logic [1:0] sel;
      logic [7:0] out;
      logic       valid;
   } vec_t;

   vec_t vecs[19];
   logic [7:0] dat[4];

   function automatic vec_t mk(logic [3:0] r, logic [7:0] d0, logic [3:0] g,
                               logic [1:0] s, logic [7:0] o, logic v);
      vec_t x;
      x.req = r; x.i0 = d0; x.grant = g; x.sel = s; x.out = o; x.valid = v;
      return x;
   endfunction

   // Grant shape monitor: zero/one-hot, sel matches grant, sel stable in tenure.
   logic [3:0] prev_grant = 4'b0000;
   logic [1:0] prev_sel   = 2'd0;
   always @(negedge clk) begin
      if (rst_n) begin
         chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
         if (bus.grant != 4'b0000)
            chk("sel_matches_grant", 32'(bus.grant), 32'(4'b0001 << bus.sel));
         if (prev_grant != 4'b0000 && bus.grant != 4'b0000)
            chk("sel_stable", 32'(bus.sel), 32'(prev_sel));
      end
      prev_grant = bus.grant;
      prev_sel   = bus.sel;
   end

   task automatic do_reset();
      rst_n   = 1'b0;
      bus.req = 4'b0000;
      bus.i0  = dat[0];
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      dat[0] = 8'hA5; dat[1] = 8'hB1; dat[2] = 8'hC2; dat[3] = 8'hD3;
      bus.req = 4'b0000;
      bus.i0 = dat[0]; bus.i1 = dat[1]; bus.i2 = dat[2]; bus.i3 = dat[3];

      //             req      i0     grant    sel   out    valid
      vecs[0]  = mk(4'b0001, 8'hA5, 4'b0001, 2'd0, 8'h00, 1'b0);
      vecs[1]  = mk(4'b0001, 8'hA5, 4'b0001, 2'd0, 8'hA5, 1'b1);
      vecs[2]  = mk(4'b0001, 8'h5A, 4'b0001, 2'd0, 8'h5A, 1'b1);
      vecs[3]  = mk(4'b0000, 8'h5A, 4'b0000, 2'd0, 8'h5A, 1'b0);
      vecs[4]  = mk(4'b0000, 8'h5A, 4'b0000, 2'd0, 8'h5A, 1'b0);
      vecs[5]  = mk(4'b1111, 8'h5A, 4'b0010, 2'd1, 8'h5A, 1'b0);
      vecs[6]  = mk(4'b1111, 8'h5A, 4'b0010, 2'd1, 8'hB1, 1'b1);
      vecs[7]  = mk(4'b1101, 8'h5A, 4'b0000, 2'd1, 8'hB1, 1'b0);
      vecs[8]  = mk(4'b1111, 8'h5A, 4'b0100, 2'd2, 8'hB1, 1'b0);
      vecs[9]  = mk(4'b1100, 8'h5A, 4'b0100, 2'd2, 8'hC2, 1'b1);
      vecs[10] = mk(4'b1000, 8'h5A, 4'b0000, 2'd2, 8'hC2, 1'b0);
      vecs[11] = mk(4'b1000, 8'h5A, 4'b1000, 2'd3, 8'hC2, 1'b0);
      vecs[12] = mk(4'b1001, 8'h5A, 4'b1000, 2'd3, 8'hD3, 1'b1);
      vecs[13] = mk(4'b0001, 8'h5A, 4'b0000, 2'd3, 8'hD3, 1'b0);
      vecs[14] = mk(4'b0001, 8'h5A, 4'b0001, 2'd0, 8'hD3, 1'b0);
      vecs[15] = mk(4'b0000, 8'h5A, 4'b0000, 2'd0, 8'hD3, 1'b0);
      vecs[16] = mk(4'b0010, 8'h5A, 4'b0010, 2'd1, 8'hD3, 1'b0);
      vecs[17] = mk(4'b0000, 8'h5A, 4'b0000, 2'd1, 8'hD3, 1'b0);
      vecs[18] = mk(4'b0000, 8'h5A, 4'b0000, 2'd1, 8'hD3, 1'b0);

      // Reset state.
      rst_n = 1'b0;
      #12;
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_sel", 32'(bus.sel), 32'd0);
      chk("rst_out", 32'(bus.out), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Cycle table.
      for (int i = 0; i < 19; i++) begin
         bus.req = vecs[i].req;
         bus.i0  = vecs[i].i0;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vecs[i].grant));
         chk($sformatf("vec%0d_sel", i), 32'(bus.sel), 32'(vecs[i].sel));
         chk($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vecs[i].out));
         chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].valid));
         @(negedge clk);
      end

      // Full rotation: all request, each owner drops after 3 grant cycles.
      do_reset();
      bus.req = 4'b1111;
      @(posedge clk);
      #1;
      for (int t = 0; t < 5; t++) begin
         chk($sformatf("rot%0d_grant", t), 32'(bus.grant), 32'(4'b0001 << (t % 4)));
         for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rot%0d_hold", t), 32'(bus.grant), 32'(4'b0001 << (t % 4)));
            chk($sformatf("rot%0d_out", t), 32'(bus.out), 32'(dat[t % 4]));
            chk($sformatf("rot%0d_valid", t), 32'(bus.out_valid), 32'd1);
         end
         @(negedge clk);
         bus.req = 4'b1111 & ~(4'b0001 << (t % 4));
         @(posedge clk);
         #1;
         chk($sformatf("rot%0d_switch_grant", t), 32'(bus.grant), 32'd0);
         chk($sformatf("rot%0d_switch_valid", t), 32'(bus.out_valid), 32'd0);
         @(negedge clk);
         bus.req = 4'b1111;
         @(posedge clk);
         #1;
      end

      // Asynchronous reset in the middle of source 3's tenure.
      do_reset();
      bus.req = 4'b1000;
      @(posedge clk);
      #1;
      chk("arst_pre_grant", 32'(bus.grant), 32'b1000);
      @(posedge clk);
      #1;
      chk("arst_pre_out", 32'(bus.out), 32'hD3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_grant", 32'(bus.grant), 32'd0);
      chk("arst_out", 32'(bus.out), 32'd0);
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_sel", 32'(bus.sel), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      bus.req = 4'b1001;
      @(posedge clk);
      #1;
      chk("arst_restart_grant", 32'(bus.grant), 32'b0001);

`ifdef MUX_41_ARB_TIMEOUT_EN
      // Tenure limit: HOLD_MAX = 4 forces a handover while req stays high.
      do_reset();
      bus.req = 4'b0011;
      begin
         int held;
         held = 0;
         @(posedge clk);
         #1;
         for (int n = 0; n < 12 && bus.grant == 4'b0001; n++) begin
            held++;
            @(posedge clk);
            #1;
         end
         chk("tmo_held_cycles", 32'(held), 32'd4);
         chk("tmo_switch_grant", 32'(bus.grant), 32'd0);
         @(posedge clk);
         #1;
         chk("tmo_next_grant", 32'(bus.grant), 32'b0010);
      end
`else
      // No tenure limit: the owner keeps the grant while it requests.
      do_reset();
      bus.req = 4'b0011;
      repeat (20) @(posedge clk);
      #1;
      chk("hold_forever_grant", 32'(bus.grant), 32'b0001);
      chk("hold_forever_valid", 32'(bus.out_valid), 32'd1);
`endif

      @(negedge clk);
      bus.req = 4'b0000;
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
